// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing signal bundle for branch_resolver.
// The fetch/execute side drives through master; the resolver uses slave.
interface branch_resolver_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // pred_* is a valid/ready push: the entry is taken on a rising edge where
  // pred_valid && pred_ready. ex_valid has no ready; it is accepted
  // unconditionally, and an empty FIFO only raises underflow_err.
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic          pred_ready;
  logic          ex_valid;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic          branch_resolved;
  logic          branch_outcome;
  logic [31:0]   branch_pc;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] inflight_count;
  logic          underflow_err;

  modport master (
    output pred_valid, pred_pc, pred_taken, ex_valid, ex_taken, ex_target,
    input  pred_ready, branch_resolved, branch_outcome, branch_pc,
           mispredict, redirect_pc, inflight_count, underflow_err
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, ex_valid, ex_taken, ex_target,
    output pred_ready, branch_resolved, branch_outcome, branch_pc,
           mispredict, redirect_pc, inflight_count, underflow_err
  );
endinterface

// File: rtl/branch_resolver.sv
// In-flight branch FIFO: matches execute outcomes against predictions in order,
// emits predictor updates and a mispredict redirect that flushes younger entries.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_mem_pc    [DEPTH];
  logic          r_mem_taken [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          r_resolved;
  logic          r_outcome;
  logic [31:0]   r_bpc;
  logic          r_mispredict;
  logic [31:0]   r_redirect;
  logic          r_underflow;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_mis;
  logic [31:0]   w_entry_pc;
  logic          w_entry_taken;

  // Refuse pushes while the redirect is visible: fetch is still on the wrong path.
  assign w_ready       = (r_count < CW'(DEPTH)) && !r_mispredict;
  assign w_push        = bus.pred_valid && w_ready;
  assign w_pop         = bus.ex_valid && (r_count != '0);
  assign w_entry_pc    = r_mem_pc[r_rptr];
  assign w_entry_taken = r_mem_taken[r_rptr];
  assign w_mis         = w_pop && (bus.ex_taken != w_entry_taken);

  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_mem_pc[r_wptr]    <= bus.pred_pc;
      r_mem_taken[r_wptr] <= bus.pred_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (w_mis) begin
      // Everything younger than the mispredicted branch is wrong-path.
      r_rptr  <= r_rptr + AW'(1);
      r_wptr  <= r_rptr + AW'(1);
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resolved   <= 1'b0;
      r_outcome    <= 1'b0;
      r_bpc        <= 32'h0;
      r_mispredict <= 1'b0;
      r_redirect   <= 32'h0;
      r_underflow  <= 1'b0;
    end else begin
      r_resolved   <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) begin
        r_outcome <= bus.ex_taken;
        r_bpc     <= w_entry_pc;
      end
      if (w_mis) r_redirect <= bus.ex_taken ? bus.ex_target : w_entry_pc + 32'd4;
      if (bus.ex_valid && (r_count == '0)) r_underflow <= 1'b1;
    end
  end

  assign bus.pred_ready      = w_ready;
  assign bus.branch_resolved = r_resolved;
  assign bus.branch_outcome  = r_outcome;
  assign bus.branch_pc       = r_bpc;
  assign bus.mispredict      = r_mispredict;
  assign bus.redirect_pc     = r_redirect;
  assign bus.inflight_count  = r_count;
  assign bus.underflow_err   = r_underflow;
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side partner of the branch predictor. Holds a FIFO of in-flight predicted branches pushed by fetch, matches each against the actual outcome reported by execute in program order, and produces the predictor update (`branch_resolved`/`branch_outcome`/`branch_pc`). On a mispredict it also produces a one-cycle mispredict/redirect and flushes all younger wrong-path entries. It sits between the fetch stage (predictor side) and the execute stage.

## Interface
- `DEPTH`, 4, in-flight branch entries; power of two, 2..16
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `pred_valid`  input  1  fetch issues a predicted branch this cycle
- `pred_pc`  input  32  PC of that branch
- `pred_taken`  input  1  prediction given (1 taken)
- `pred_ready`  output  1  entry accepted this cycle if `pred_valid`
- `ex_valid`  input  1  execute resolves the oldest in-flight branch
- `ex_taken`  input  1  actual outcome
- `ex_target`  input  32  actual taken target
- `branch_resolved`  output  1  one-cycle pulse: predictor update valid
- `branch_outcome`  output  1  actual outcome for update
- `branch_pc`  output  32  PC of resolved branch
- `mispredict`  output  1  one-cycle pulse: prediction was wrong
- `redirect_pc`  output  32  correct fetch PC, valid with `mispredict`
- `inflight_count`  output  $clog2(DEPTH+1)  current FIFO occupancy
- `underflow_err`  output  1  sticky: `ex_valid` seen with empty FIFO

## Operation
- Storage: DEPTH entries of {pc[31:0], taken}; read pointer, write pointer (log2 DEPTH bits, natural wrap), occupancy counter 0..DEPTH.
- `pred_ready` = (count < DEPTH) && !mispredict; combinational from registered state only.
- Push: `pred_valid && pred_ready` writes {pred_pc, pred_taken} at wptr, wptr+1.
- Pop: `ex_valid && count != 0` reads entry at rptr, rptr+1. Next cycle: `branch_resolved`=1, `branch_outcome`=ex_taken, `branch_pc`=entry pc.
- Mispredict check at pop: ex_taken != entry taken -> next cycle `mispredict`=1, `redirect_pc` = ex_taken ? ex_target : entry pc + 32'd4 (mod 2^32 wrap).
- Flush: on a mispredicting pop, at that same edge count<=0 and wptr<=rptr+1 (all younger entries discarded); any push in that cycle is discarded, not stored.
- During the cycle `mispredict`=1, `pred_ready`=0 (fetch still on wrong path); pushes refused. Pops that cycle are impossible (count=0) and count as underflow if `ex_valid`.
- Simultaneous push+pop without mispredict: count unchanged, both pointers advance. Push while full refused (pred_ready=0) even if a pop occurs same cycle.
- Empty-FIFO `ex_valid`: no outputs asserted, pointers unchanged, `underflow_err` set and held until reset.
- Correct prediction: `mispredict`=0, `redirect_pc` holds previous value.

## Timing
- Reset (async assert, sync release): all outputs 0 (`branch_pc`, `redirect_pc` = 32'h0), pointers/count 0, `underflow_err`=0; `pred_ready`=1 immediately after reset deasserts.
- Reset mid-operation discards every in-flight entry; no resolve pulse emitted for them.
- Latency: `ex_valid` at edge N -> `branch_resolved`/`mispredict` high for exactly the cycle after edge N, low otherwise unless another pop at N+1.
- Back-to-back pops each cycle yield back-to-back resolve pulses.
- `inflight_count` reflects state after the most recent edge.

## Test plan
- Push PCs 0x100(T),0x104(N),0x108(T); resolve T,N,T -> three consecutive `branch_resolved` pulses, `branch_pc` 0x100,0x104,0x108, `mispredict` never high, count 3->0.
- Push 0x200(N),0x204(T),0x208(N); resolve first as taken, ex_target=0x400 -> `mispredict`=1, `redirect_pc`=0x400, count=0, `pred_ready`=0 that cycle, 1 next; later resolve produces `underflow_err`=1.
- Push 0x300(T); resolve not-taken -> `redirect_pc`=0x304; push 0xFFFFFFFC(T), resolve not-taken -> `redirect_pc`=0x00000000.
- DEPTH=4: push 5 -> `pred_ready`=0 after 4th, 5th not stored; pop+push same cycle when full -> push refused, count 3; then fill and drain twice to exercise pointer wrap, order preserved.
- Mispredicting pop with simultaneous `pred_valid` (pc 0x500) -> 0x500 not stored, count=0.
- Assert reset with 3 entries in flight mid-cycle -> outputs 0 asynchronously, count 0, no resolve pulses after release.
